mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single data-memory/IO bus between two masters: CPU data port (m0) and monitor port (m1).
- The bus drives address_decoder, data RAM and the IO ports; the read mux result returns as bus_rdata.
- Sequences each access as request → grant → access → wait → ack. Round-robin arbitration, so neither master starves.

Parameters:
- RD_LATENCY, 1, cycles from the ACCESS cycle until bus_rdata is valid (legal range 1..4).

Ports:
- clk  in  1  system clock; everything is updated on the rising edge.
- reset  in  1  synchronous reset, active-high.
- m0_req  in  1  CPU request; held high until m0_ack.
- m0_we  in  1  CPU write (1) or read (0).
- m0_addr  in  32  CPU byte address.
- m0_wdata  in  32  CPU write data.
- m0_ack  out  1  one-cycle completion pulse to the CPU.
- m0_rdata  out  32  CPU read data; valid while m0_ack is high.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: monitor equivalents of the m0 ports, same directions and widths.
- bus_we  out  1  write enable to address_decoder.
- bus_addr  out  32  address to address_decoder and memories.
- bus_wdata  out  32  write data to memories and IO.
- bus_rdata  in  32  read data from the RAM/IO read mux.
- busy  out  1  high in every state except IDLE.
- gnt  out  1  current or last owner (0 = CPU, 1 = monitor).

Behaviour:
- Reset values: state IDLE; all ack outputs 0; bus_we 0; bus_addr 0; bus_wdata 0; both rdata outputs 0; last_grant 1 (so the CPU wins the first tie); gnt 1; wait counter 0.
- Reset mid-transaction aborts it: return to IDLE, raise no ack, and deassert bus_we in the same edge.
- State IDLE:
  - No request → stay in IDLE.
  - Exactly one request → grant that master.
  - Both requesting → grant the master that is not last_grant.
  - On grant, register that master's we/addr/wdata into the command register, set gnt and last_grant, and go to ACCESS.
- State ACCESS (exactly 1 cycle):
  - bus_addr and bus_wdata come from the command register.
  - bus_we = command we; this is the only cycle in which bus_we may be 1.
  - Write → DONE. Read → WAIT with counter loaded to RD_LATENCY-1.
- State WAIT:
  - bus_addr is held and bus_we is 0.
  - While counter > 0, decrement it.
  - When counter = 0, capture bus_rdata into the rdata register and go to DONE.
  - The read spans RD_LATENCY WAIT cycles in total.
- State DONE (exactly 1 cycle):
  - Raise the ack of the granted master only; its rdata output = rdata register (reads).
  - The other master's ack is 0 and its rdata holds its previous value.
  - Always go to IDLE.
- Latency, with the request seen in IDLE at cycle 0:
  - Write: bus_we in cycle 1, ack in cycle 2.
  - Read: ack in cycle 2+RD_LATENCY; with RD_LATENCY=1, ack in cycle 3.
- Master handshake rules:
  - After its ack, a master must drop req in the following cycle.
  - A req still high in the IDLE cycle after ack is treated as a new transaction.
  - Master inputs may change after grant; the command register isolates the bus from them.
- A request arriving while busy waits; it is served at the next IDLE. The minimum gap between bus transactions is one IDLE cycle.
- A master rdata output changes only on that master's read completion. Writes leave it unchanged.
- Address decoding and IO-port selection are not performed here; bus_addr is passed through unmodified.

Decomposition:
- Shared package (mem_bus_pkg):
  - State encoding localparams: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3.
  - Master IDs: M_CPU=1'b0, M_MON=1'b1.
  - Bus width constant: 32.
- One sub-module, rr_arbiter2: combinational 2-way round-robin pick from req[1:0] and last_grant. It outputs a valid flag and the chosen ID.
- FSM, command register, counter and rdata register stay in mem_bus_arbiter.

Test Plan:
- CPU write: m0_req, we=1, addr=0x0000_0010, wdata=0xDEAD_BEEF → bus_we=1 with that addr/wdata in cycle 1 only; m0_ack=1 in cycle 2; m1_ack stays 0.
- Monitor read, RD_LATENCY=1, bus_rdata=0x1234_5678 from the RAM model at 0x0000_1004 → m1_ack in cycle 3 with m1_rdata=0x1234_5678; bus_we 0 throughout.
- Simultaneous requests from reset: both reqs high, CPU write to 0x2000 then monitor read of 0x2004 → CPU granted first (gnt=0) with ack in cycle 2. IDLE in cycle 3, monitor granted, gnt=1.
- Fairness: both masters hold continuous back-to-back requests for 8 transactions → grants alternate 0,1,0,1…; no master is ever granted twice in a row while the other waits.
- Reset mid-read: assert reset during WAIT with RD_LATENCY=4 → next cycle is IDLE; no ack; bus_we 0; rdata outputs 0; gnt 1.
- RD_LATENCY=3 read of IO port 0x200C returning 0x0000_00A5 → ack exactly 5 cycles after the IDLE grant cycle; bus_addr held at 0x200C through all WAIT cycles.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the data-memory/IO bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package mem_bus_pkg;

    localparam int BUS_W = 32;
    localparam int CNT_W = 2;

    localparam logic M_CPU = 1'b0;
    localparam logic M_MON = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic             we;
        logic [BUS_W-1:0] addr;
        logic [BUS_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Combinational two-way round-robin pick.
// On a tie the master that did not own the bus last time wins.
import mem_bus_pkg::*;

module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       id
);

    always_comb begin
        valid = |req;
        id    = M_CPU;
        unique case (req)
            2'b01:   id = M_CPU;
            2'b10:   id = M_MON;
            2'b11:   id = ~last_grant;
            default: id = M_CPU;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master data bus arbiter: CPU data port and monitor port share
// one bus through an IDLE -> ACCESS -> WAIT -> DONE sequence.
import mem_bus_pkg::*;

module mem_bus_arbiter #(
    parameter int RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [BUS_W-1:0] m0_addr,
    input  logic [BUS_W-1:0] m0_wdata,
    output logic             m0_ack,
    output logic [BUS_W-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [BUS_W-1:0] m1_addr,
    input  logic [BUS_W-1:0] m1_wdata,
    output logic             m1_ack,
    output logic [BUS_W-1:0] m1_rdata,
    output logic             bus_we,
    output logic [BUS_W-1:0] bus_addr,
    output logic [BUS_W-1:0] bus_wdata,
    input  logic [BUS_W-1:0] bus_rdata,
    output logic             busy,
    output logic             gnt
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);

    state_t           state;
    state_t           state_nx;
    cmd_t             cmd;
    logic [CNT_W-1:0] cnt;
    logic [BUS_W-1:0] rdata;
    logic [BUS_W-1:0] m0_hold;
    logic [BUS_W-1:0] m1_hold;
    logic             last_grant;
    logic             pick_valid;
    logic             pick_id;
    logic             grant_en;
    logic             rd_done;
    logic             done_rd;

    rr_arbiter2 u_rr (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .id         (pick_id)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant_en = 1'b0;
        rd_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_en = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                state_nx = cmd.we ? DONE : WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    rd_done  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Command register decouples the bus from master inputs after grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd        <= '0;
            last_grant <= M_MON;
        end else if (grant_en) begin
            last_grant <= pick_id;
            if (pick_id == M_MON) cmd <= '{m1_we, m1_addr, m1_wdata};
            else                  cmd <= '{m0_we, m0_addr, m0_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ACCESS && !cmd.we) begin
            cnt <= CNT_INIT;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rdata <= '0;
        else if (rd_done) rdata <= bus_rdata;
    end

    assign done_rd = (state == DONE) && !cmd.we;

    // Per-master copies only move when that master's read completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_hold <= '0;
            m1_hold <= '0;
        end else if (done_rd) begin
            if (last_grant == M_MON) m1_hold <= rdata;
            else                     m0_hold <= rdata;
        end
    end

    assign m0_rdata = (done_rd && last_grant == M_CPU) ? rdata : m0_hold;
    assign m1_rdata = (done_rd && last_grant == M_MON) ? rdata : m1_hold;

    assign m0_ack    = (state == DONE) && (last_grant == M_CPU);
    assign m1_ack    = (state == DONE) && (last_grant == M_MON);
    assign bus_we    = (state == ACCESS) && cmd.we;
    assign bus_addr  = cmd.addr;
    assign bus_wdata = cmd.wdata;
    assign busy      = (state != IDLE);
    assign gnt       = last_grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter at read latencies 1, 3 and 4.
// One instance is observed per scenario; all share master stimulus.
module tb_mem_bus_arbiter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_ack_a   [N];
    logic        m1_ack_a   [N];
    logic [31:0] m0_rdata_a [N];
    logic [31:0] m1_rdata_a [N];
    logic        bus_we_a   [N];
    logic [31:0] bus_addr_a [N];
    logic [31:0] bus_wdata_a[N];
    logic [31:0] bus_rdata_a[N];
    logic        busy_a     [N];
    logic        gnt_a      [N];

    int sel = 0;
    int cyc = 0;
    bit init_ram = 1'b1;
    logic [31:0] ram [4096];

    logic        m0_ack_s, m1_ack_s, bus_we_s, busy_s, gnt_s;
    logic [31:0] m0_rdata_s, m1_rdata_s, bus_addr_s, bus_wdata_s;

    typedef struct {
        bit          m;
        bit          we;
        logic [31:0] rdata;
        int          cyc;
        bit          chk_cyc;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_pass = 0;
    int we_cnt, we_cyc, addr_bad;
    logic [31:0] we_addr, we_data, hold_addr;
    bit hold_on = 1'b0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_bus_arbiter #(
            .RD_LATENCY ((g == 0) ? 1 : (g == 1) ? 3 : 4)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .m0_req    (m0_req),
            .m0_we     (m0_we),
            .m0_addr   (m0_addr),
            .m0_wdata  (m0_wdata),
            .m0_ack    (m0_ack_a[g]),
            .m0_rdata  (m0_rdata_a[g]),
            .m1_req    (m1_req),
            .m1_we     (m1_we),
            .m1_addr   (m1_addr),
            .m1_wdata  (m1_wdata),
            .m1_ack    (m1_ack_a[g]),
            .m1_rdata  (m1_rdata_a[g]),
            .bus_we    (bus_we_a[g]),
            .bus_addr  (bus_addr_a[g]),
            .bus_wdata (bus_wdata_a[g]),
            .bus_rdata (bus_rdata_a[g]),
            .busy      (busy_a[g]),
            .gnt       (gnt_a[g])
        );
        assign bus_rdata_a[g] = ram[bus_addr_a[g][13:2]];
    end

    assign m0_ack_s    = m0_ack_a[sel];
    assign m1_ack_s    = m1_ack_a[sel];
    assign m0_rdata_s  = m0_rdata_a[sel];
    assign m1_rdata_s  = m1_rdata_a[sel];
    assign bus_we_s    = bus_we_a[sel];
    assign bus_addr_s  = bus_addr_a[sel];
    assign bus_wdata_s = bus_wdata_a[sel];
    assign busy_s      = busy_a[sel];
    assign gnt_s       = gnt_a[sel];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (init_ram) begin
            ram[12'h401] <= 32'h1234_5678;
            ram[12'h801] <= 32'h0BAD_F00D;
            ram[12'h803] <= 32'h0000_00A5;
        end else if (bus_we_s) begin
            ram[bus_addr_s[13:2]] <= bus_wdata_s;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic issue(input bit m, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        if (!m) begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic expect_txn(input bit m, input bit we,
                              input logic [31:0] rd, input int c,
                              input bit cc);
        exp_t e;
        e.m = m; e.we = we; e.rdata = rd; e.cyc = c; e.chk_cyc = cc;
        sb.push_back(e);
    endtask

    // Steps the bus, scores every ack against the queue front.
    task automatic run(input int n_acks, input int budget, input bit keep);
        int   got;
        bit   a0, a1;
        exp_t e;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_we_s) begin
                we_cnt++;
                we_cyc  = cyc;
                we_addr = bus_addr_s;
                we_data = bus_wdata_s;
            end
            if (hold_on && busy_s && bus_addr_s !== hold_addr) addr_bad++;
            a0 = m0_ack_s;
            a1 = m1_ack_s;
            if (a0 || a1) begin
                got++;
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(a1), 32'(2));
                end else begin
                    e = sb.pop_front();
                    check("ack_master", 32'(a1), 32'(e.m));
                    check("ack_single", 32'(a0 & a1), 32'(0));
                    check("ack_gnt", 32'(gnt_s), 32'(e.m));
                    if (e.chk_cyc) check("ack_cycle", cyc, e.cyc);
                    if (!e.we)
                        check("rdata", e.m ? m1_rdata_s : m0_rdata_s, e.rdata);
                end
            end
            tick();
            if (!keep) begin
                if (a0) m0_req = 1'b0;
                if (a1) m1_req = 1'b0;
            end
            if (n_acks > 0 && got >= n_acks) break;
        end
        check("ack_count", got, n_acks);
    endtask

    initial begin
        int t0;
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        we_cnt = 0; we_cyc = 0; addr_bad = 0;
        we_addr = '0; we_data = '0; hold_addr = '0;
        do_reset();
        init_ram = 1'b0;

        // Reset state, latency 1 instance
        sel = 0;
        @(negedge clk);
        check("rst_busy", 32'(busy_s), 32'(0));
        check("rst_gnt", 32'(gnt_s), 32'(1));
        check("rst_bus_we", 32'(bus_we_s), 32'(0));
        check("rst_bus_addr", bus_addr_s, 32'h0);
        check("rst_bus_wdata", bus_wdata_s, 32'h0);
        check("rst_acks", 32'({m0_ack_s, m1_ack_s}), 32'(0));
        check("rst_rdata", m0_rdata_s | m1_rdata_s, 32'h0);

        // CPU write
        tick();
        t0 = cyc;
        we_cnt = 0;
        issue(0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
        expect_txn(0, 1, '0, t0 + 2, 1);
        run(1, 20, 0);
        check("wr_we_cnt", we_cnt, 1);
        check("wr_we_cyc", we_cyc, t0 + 1);
        check("wr_bus_addr", we_addr, 32'h0000_0010);
        check("wr_bus_wdata", we_data, 32'hDEAD_BEEF);
        check("wr_m0_rdata_kept", m0_rdata_s, 32'h0);

        // Monitor read, latency 1
        tick();
        t0 = cyc;
        we_cnt = 0;
        issue(1, 0, 32'h0000_1004, 32'h0);
        expect_txn(1, 0, 32'h1234_5678, t0 + 3, 1);
        run(1, 20, 0);
        check("rd_bus_we_low", we_cnt, 0);
        @(negedge clk);
        check("rd_m1_rdata_hold", m1_rdata_s, 32'h1234_5678);
        check("rd_m0_rdata_kept", m0_rdata_s, 32'h0);

        // Simultaneous requests from reset
        do_reset();
        tick();
        t0 = cyc;
        issue(0, 1, 32'h0000_2000, 32'hCAFE_0001);
        issue(1, 0, 32'h0000_2004, 32'h0);
        expect_txn(0, 1, '0, t0 + 2, 1);
        expect_txn(1, 0, 32'h0BAD_F00D, t0 + 6, 1);
        run(2, 30, 0);

        // Fairness under continuous requests from both masters
        do_reset();
        tick();
        issue(0, 1, 32'h0000_3000, 32'h5555_AAAA);
        issue(1, 0, 32'h0000_1004, 32'h0);
        for (int i = 0; i < 8; i++)
            expect_txn(i[0], ~i[0], 32'h1234_5678, 0, 0);
        run(8, 120, 1);
        m0_req = 1'b0;
        m1_req = 1'b0;
        run(0, 4, 0);

        // Reset in the middle of a latency-4 read
        sel = 2;
        do_reset();
        tick();
        t0 = cyc;
        issue(1, 0, 32'h0000_1004, 32'h0);
        expect_txn(1, 0, 32'h1234_5678, t0 + 6, 1);
        run(1, 20, 0);
        tick();
        issue(1, 0, 32'h0000_1004, 32'h0);
        repeat (3) tick();
        @(negedge clk);
        check("mid_busy", 32'(busy_s), 32'(1));
        reset  = 1'b1;
        m1_req = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy_s), 32'(0));
        check("abort_ack", 32'({m0_ack_s, m1_ack_s}), 32'(0));
        check("abort_bus_we", 32'(bus_we_s), 32'(0));
        check("abort_rdata", m0_rdata_s | m1_rdata_s, 32'h0);
        check("abort_gnt", 32'(gnt_s), 32'(1));
        tick();
        run(0, 8, 0);

        // Latency-3 read from an IO address
        sel = 1;
        do_reset();
        tick();
        t0 = cyc;
        we_cnt = 0;
        addr_bad = 0;
        hold_addr = 32'h0000_200C;
        hold_on = 1'b1;
        issue(0, 0, 32'h0000_200C, 32'h0);
        expect_txn(0, 0, 32'h0000_00A5, t0 + 5, 1);
        run(1, 20, 0);
        hold_on = 1'b0;
        check("io_addr_held", addr_bad, 0);
        check("io_bus_we_low", we_cnt, 0);
        check("io_sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
